// File: rtl/pic_inta_sequencer.sv
// 8259A interrupt-acknowledge sequencer: raises INT, tracks the two INTA pulses,
// steers the cascade controller and decides whether this PIC drives the vector.
module pic_inta_sequencer #(
  parameter logic [2:0] SPURIOUS_LVL = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inta_n,
  input  logic       sp,
  input  logic [7:0] icw3,
  input  logic [4:0] icw2_base,
  input  logic       aeoi,
  input  logic       int_valid,
  input  logic [2:0] int_level,
  input  logic       slave_flag,
  output logic       int_out,
  output logic       control_signal,
  output logic [2:0] desired_slave,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       isr_set,
  output logic [2:0] isr_level,
  output logic       eoi_auto
);

  typedef enum logic [2:0] {IDLE, REQ, ACK1, GAP, ACK2} state_t;

  state_t     state_q, state_d;
  logic       inta_n_q;
  logic [2:0] lvl_q, lvl_d;
  logic       own_q, own_d;
  logic       cas_sel_q, cas_sel_d;
  logic       int_out_q, int_out_d;
  logic       ctrl_q, ctrl_d;
  logic [2:0] desired_q, desired_d;
  logic       data_oe_q, data_oe_d;
  logic       isr_set_q, isr_set_d;
  logic       eoi_q, eoi_d;
  logic       fall, rise, drive;

  assign fall  = inta_n_q & ~inta_n;
  assign rise  = ~inta_n_q & inta_n;
  // A master with a cascaded slave on this level leaves the bus to that slave.
  assign drive = (sp & ~cas_sel_q) | (~sp & slave_flag & own_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      inta_n_q  <= 1'b1;
      lvl_q     <= 3'd0;
      own_q     <= 1'b0;
      cas_sel_q <= 1'b0;
      int_out_q <= 1'b0;
      ctrl_q    <= 1'b0;
      desired_q <= 3'd0;
      data_oe_q <= 1'b0;
      isr_set_q <= 1'b0;
      eoi_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      inta_n_q  <= inta_n;
      lvl_q     <= lvl_d;
      own_q     <= own_d;
      cas_sel_q <= cas_sel_d;
      int_out_q <= int_out_d;
      ctrl_q    <= ctrl_d;
      desired_q <= desired_d;
      data_oe_q <= data_oe_d;
      isr_set_q <= isr_set_d;
      eoi_q     <= eoi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    own_d     = own_q;
    cas_sel_d = cas_sel_q;
    int_out_d = int_out_q;
    ctrl_d    = ctrl_q;
    desired_d = desired_q;
    data_oe_d = data_oe_q;
    isr_set_d = 1'b0;
    eoi_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (int_valid) begin
          int_out_d = 1'b1;
          state_d   = REQ;
        end else if (~sp & fall) begin
          // Slave follows a cycle aimed at another PIC without owning it.
          own_d   = 1'b0;
          state_d = ACK1;
        end
      end
      REQ: begin
        // INT stays high even if the request vanishes; the fall resolves it.
        if (fall) begin
          lvl_d     = int_valid ? int_level : SPURIOUS_LVL;
          own_d     = int_valid;
          isr_set_d = int_valid;
          int_out_d = 1'b0;
          state_d   = ACK1;
        end
      end
      ACK1: begin
        ctrl_d = 1'b1;
        if (sp) begin
          cas_sel_d = icw3[lvl_q];
          desired_d = icw3[lvl_q] ? lvl_q : 3'd0;
        end else begin
          cas_sel_d = 1'b0;
          desired_d = 3'd0;
        end
        if (rise) state_d = GAP;
      end
      GAP: begin
        if (fall) begin
          data_oe_d = drive;
          state_d   = ACK2;
        end
      end
      ACK2: begin
        if (rise) begin
          data_oe_d = 1'b0;
          ctrl_d    = 1'b0;
          desired_d = 3'd0;
          eoi_d     = aeoi & own_q;
          state_d   = IDLE;
        end else begin
          data_oe_d = drive;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign int_out        = int_out_q;
  assign control_signal = ctrl_q;
  assign desired_slave  = desired_q;
  assign data_oe        = data_oe_q;
  assign data_out       = data_oe_q ? {icw2_base, lvl_q} : 8'h00;
  assign isr_set        = isr_set_q;
  assign isr_level      = lvl_q;
  assign eoi_auto       = eoi_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed and randomized INTA transactions checked against a per-transaction
// model derived from the acknowledge rules of the 8259A.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, inta_n, sp, aeoi, int_valid, slave_flag;
  logic [7:0] icw3;
  logic [4:0] icw2_base;
  logic [2:0] int_level;
  logic       int_out, control_signal, data_oe, isr_set, eoi_auto;
  logic [2:0] desired_slave, isr_level;
  logic [7:0] data_out;

  int vectors = 0;
  int miscompares = 0;

  pic_inta_sequencer dut (
    .clk(clk), .rst_n(rst_n), .inta_n(inta_n), .sp(sp), .icw3(icw3),
    .icw2_base(icw2_base), .aeoi(aeoi), .int_valid(int_valid),
    .int_level(int_level), .slave_flag(slave_flag), .int_out(int_out),
    .control_signal(control_signal), .desired_slave(desired_slave),
    .data_out(data_out), .data_oe(data_oe), .isr_set(isr_set),
    .isr_level(isr_level), .eoi_auto(eoi_auto)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_int_out"}, {7'd0, int_out}, 8'd0);
    chk({tag, "_ctrl"}, {7'd0, control_signal}, 8'd0);
    chk({tag, "_desired"}, {5'd0, desired_slave}, 8'd0);
    chk({tag, "_data_out"}, data_out, 8'd0);
    chk({tag, "_data_oe"}, {7'd0, data_oe}, 8'd0);
    chk({tag, "_isr_set"}, {7'd0, isr_set}, 8'd0);
    chk({tag, "_isr_level"}, {5'd0, isr_level}, 8'd0);
    chk({tag, "_eoi"}, {7'd0, eoi_auto}, 8'd0);
  endtask

  // One full request + INTA pair; abort=1 pulls reset during the gap.
  task automatic run_txn(input logic m, input logic [7:0] c3, input logic [4:0] b,
                         input logic ae, input logic [2:0] l, input logic drop,
                         input logic sf, input logic abort);
    logic [2:0] e_lvl;
    logic       e_own, e_cas, e_drive, e_eoi;
    logic [2:0] e_desired;
    e_lvl     = drop ? 3'd7 : l;
    e_own     = ~drop;
    e_cas     = m & c3[e_lvl];
    e_desired = e_cas ? e_lvl : 3'd0;
    e_drive   = m ? ~e_cas : (sf & e_own);
    e_eoi     = ae & e_own;

    sp = m; icw3 = c3; icw2_base = b; aeoi = ae; slave_flag = sf;
    int_level = l; int_valid = 1'b1; inta_n = 1'b1;
    tick;
    chk("int_out_raise", {7'd0, int_out}, 8'd1);
    if (drop) begin
      int_valid = 1'b0;
      tick;
      chk("int_out_hold", {7'd0, int_out}, 8'd1);
    end
    inta_n = 1'b0;
    tick;
    chk("int_out_drop", {7'd0, int_out}, 8'd0);
    chk("isr_set_pulse", {7'd0, isr_set}, {7'd0, e_own});
    if (e_own) chk("isr_level_set", {5'd0, isr_level}, {5'd0, e_lvl});
    chk("oe_ack1", {7'd0, data_oe}, 8'd0);
    tick;
    chk("isr_set_end", {7'd0, isr_set}, 8'd0);
    chk("ctrl_ack1", {7'd0, control_signal}, 8'd1);
    chk("desired_ack1", {5'd0, desired_slave}, {5'd0, e_desired});
    inta_n = 1'b1;
    tick;
    tick;
    if (abort) begin
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_gap");
      int_valid = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      chk_all_zero("rst_release");
      return;
    end
    int_valid = 1'b0;
    inta_n = 1'b0;
    tick;
    chk("oe_ack2", {7'd0, data_oe}, {7'd0, e_drive});
    chk("data_ack2", data_out, e_drive ? {b, e_lvl} : 8'h00);
    chk("ctrl_ack2", {7'd0, control_signal}, 8'd1);
    chk("desired_ack2", {5'd0, desired_slave}, {5'd0, e_desired});
    chk("eoi_early", {7'd0, eoi_auto}, 8'd0);
    tick;
    chk("oe_ack2_hold", {7'd0, data_oe}, {7'd0, e_drive});
    inta_n = 1'b1;
    tick;
    chk("oe_done", {7'd0, data_oe}, 8'd0);
    chk("ctrl_done", {7'd0, control_signal}, 8'd0);
    chk("desired_done", {5'd0, desired_slave}, 8'd0);
    chk("eoi_pulse", {7'd0, eoi_auto}, {7'd0, e_eoi});
    chk("isr_set_done", {7'd0, isr_set}, 8'd0);
    if (e_eoi) chk("eoi_level", {5'd0, isr_level}, {5'd0, e_lvl});
    tick;
    chk("eoi_end", {7'd0, eoi_auto}, 8'd0);
    chk("int_out_idle", {7'd0, int_out}, 8'd0);
  endtask

  // Slave without a request follows an INTA cycle but must stay silent.
  task automatic run_foreign;
    sp = 1'b0; int_valid = 1'b0; slave_flag = 1'b1; aeoi = 1'b1;
    for (int p = 0; p < 2; p++) begin
      inta_n = 1'b0;
      repeat (2) begin
        tick;
        chk("foreign_oe", {7'd0, data_oe}, 8'd0);
        chk("foreign_isr", {7'd0, isr_set}, 8'd0);
      end
      inta_n = 1'b1;
      repeat (2) begin
        tick;
        chk("foreign_eoi", {7'd0, eoi_auto}, 8'd0);
        chk("foreign_int", {7'd0, int_out}, 8'd0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; inta_n = 1'b1; sp = 1'b1; aeoi = 1'b0; int_valid = 1'b0;
    slave_flag = 1'b0; icw3 = 8'h00; icw2_base = 5'b01000; int_level = 3'd0;
    #12;
    chk_all_zero("reset");
    tick;
    rst_n = 1'b1;
    tick;
    chk_all_zero("post_reset");

    run_txn(1'b1, 8'h00, 5'b01000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    run_txn(1'b1, 8'h40, 5'b01000, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0);
    run_txn(1'b0, 8'h06, 5'b10000, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
    run_txn(1'b0, 8'h06, 5'b10000, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    run_txn(1'b1, 8'h00, 5'b01000, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    run_txn(1'b1, 8'h00, 5'b01000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    run_txn(1'b1, 8'h00, 5'b01000, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    run_foreign();
    run_txn(1'b1, 8'h00, 5'b01000, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1);
    run_txn(1'b1, 8'h00, 5'b01000, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(1)), 8'($urandom), 5'($urandom), 1'($urandom_range(1)),
              3'($urandom), ($urandom_range(3) == 0), 1'($urandom_range(1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
